// File: rtl/ram_map_pkg.sv
// rtl/ram_map_pkg.sv - shared BRAM map for the FFT result buffer (writer and reader sides)
// Contents: frame geometry, marker word location and encoding, reader state enum,
// mode (choise) codes and the marker validity helper.
package ram_map_pkg;

  localparam int          FRAME_WORDS  = 28;
  localparam int          FRAME_STRIDE = 112;
  localparam int          MAX_FRAMES   = 56;
  localparam logic [31:0] MARKER_ADDR  = 32'd8000;
  localparam logic [31:0] MARKER_BASE  = 32'hf0f0f0f0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_POLL,
    ST_CHECK,
    ST_READ,
    ST_PRESENT,
    ST_CLEAR,
    ST_DONE
  } state_t;

  typedef enum logic [2:0] {
    CH_MODE0 = 3'd0,
    CH_MODE1 = 3'd1,
    CH_MODE2 = 3'd2,
    CH_MODE3 = 3'd3,
    CH_MODE4 = 3'd4
  } choise_t;

  localparam logic [2:0] CHOISE_MAX = CH_MODE4;

  // Marker carries the fixed pattern in [31:3]; the low bits are the mode code.
  function automatic logic marker_valid(input logic [31:0] word, input logic [31:0] base);
    return (word[31:3] == base[31:3]) && (word[2:0] <= CHOISE_MAX);
  endfunction

endpackage

// File: rtl/word_packer.sv
// rtl/word_packer.sv - shift-in register that assembles a frame from BRAM words
// Ports:
//   clk, reset (async, active-low)
//   clear : zero the frame and the word count
//   load  : shift din in at the LSB end (first word ends up in the MSBs)
//   din   : word sampled from BRAM
//   dout  : assembled frame, WORDS*WIDTH bits
//   count : number of words shifted in since the last clear (saturates at WORDS)
module word_packer #(
  parameter int WORDS = 28,
  parameter int WIDTH = 32,
  parameter int CW    = $clog2(WORDS + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   load,
  input  logic [WIDTH-1:0]       din,
  output logic [WORDS*WIDTH-1:0] dout,
  output logic [CW-1:0]          count
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dout  <= '0;
      count <= '0;
    end else if (clear) begin
      dout  <= '0;
      count <= '0;
    end else if (load) begin
      dout <= {dout[(WORDS-1)*WIDTH-1:0], din};
      if (count != CW'(WORDS)) begin
        count <= count + CW'(1);
      end
    end
  end

endmodule

// File: rtl/r_ram.sv
// rtl/r_ram.sv - BRAM port-B reader: polls the FFT completion marker, reads back frames, clears marker
// Ports:
//   clk, reset (async, active-low)
//   rd_en        : level request, sampled only while idle
//   num_frames   : frames per session, latched when a valid marker is seen
//   addrb/clkb/enb/rstb/web/dinb/doutb : BRAM port B
//   frame_data, frame_idx, choise, frame_valid, frame_ready : frame output handshake
//   busy         : not idle
//   done         : one-cycle pulse after the marker has been cleared
//   err          : one-cycle pulse when num_frames is out of range
module r_ram
#(
  parameter int          FRAME_WORDS  = ram_map_pkg::FRAME_WORDS,
  parameter int          FRAME_STRIDE = ram_map_pkg::FRAME_STRIDE,
  parameter int          MAX_FRAMES   = ram_map_pkg::MAX_FRAMES,
  parameter logic [31:0] MARKER_ADDR  = ram_map_pkg::MARKER_ADDR,
  parameter logic [31:0] MARKER_BASE  = ram_map_pkg::MARKER_BASE,
  parameter int          RD_LAT       = 2,
  parameter int          POLL_GAP     = 16,
  parameter int          WR_HOLD      = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      rd_en,
  input  logic [5:0]                num_frames,
  output logic [31:0]               addrb,
  output logic                      clkb,
  output logic                      enb,
  output logic                      rstb,
  output logic [3:0]                web,
  output logic [31:0]               dinb,
  input  logic [31:0]               doutb,
  output logic [FRAME_WORDS*32-1:0] frame_data,
  output logic [5:0]                frame_idx,
  output logic [2:0]                choise,
  output logic                      frame_valid,
  input  logic                      frame_ready,
  output logic                      busy,
  output logic                      done,
  output logic                      err
);

  import ram_map_pkg::*;

  localparam int CW = $clog2(FRAME_WORDS + 1);
  // IDLE is entered with this count so that exactly POLL_GAP idle cycles pass before rd_en is rechecked.
  localparam logic [7:0] GAP_LOAD = (POLL_GAP > 0) ? 8'(POLL_GAP - 1) : 8'd0;

  state_t      state, state_n;
  logic [7:0]  cnt, cnt_n;
  logic [7:0]  gap, gap_n;
  logic [5:0]  k, k_n;
  logic [5:0]  num_q, num_q_n;
  logic [31:0] marker_q, marker_q_n;
  logic [2:0]  choise_n;
  logic [5:0]  frame_idx_n;

  logic          pk_load;
  logic          pk_clear;
  logic [CW-1:0] pk_count;

  assign clkb = clk;
  assign rstb = 1'b0;
  assign dinb = 32'd0;
  assign busy = (state != ST_IDLE);

  // The packer's word count doubles as the in-frame word index: word j = pk_count + 1.
  word_packer #(
    .WORDS (FRAME_WORDS),
    .WIDTH (32),
    .CW    (CW)
  ) u_packer (
    .clk   (clk),
    .reset (reset),
    .clear (pk_clear),
    .load  (pk_load),
    .din   (doutb),
    .dout  (frame_data),
    .count (pk_count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      gap       <= '0;
      k         <= '0;
      num_q     <= '0;
      marker_q  <= '0;
      choise    <= '0;
      frame_idx <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      gap       <= gap_n;
      k         <= k_n;
      num_q     <= num_q_n;
      marker_q  <= marker_q_n;
      choise    <= choise_n;
      frame_idx <= frame_idx_n;
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    gap_n       = gap;
    k_n         = k;
    num_q_n     = num_q;
    marker_q_n  = marker_q;
    choise_n    = choise;
    frame_idx_n = frame_idx;
    pk_load     = 1'b0;
    pk_clear    = 1'b0;
    addrb       = 32'd0;
    enb         = 1'b0;
    web         = 4'h0;
    frame_valid = 1'b0;
    done        = 1'b0;
    err         = 1'b0;

    case (state)
      ST_IDLE: begin
        if (gap != 8'd0) begin
          gap_n = gap - 8'd1;
        end else if (rd_en) begin
          state_n = ST_POLL;
          cnt_n   = 8'd0;
        end else begin
          gap_n = GAP_LOAD;
        end
      end

      ST_POLL: begin
        addrb = MARKER_ADDR;
        enb   = 1'b1;
        if (cnt == 8'(RD_LAT)) begin
          marker_q_n = doutb;
          cnt_n      = 8'd0;
          state_n    = ST_CHECK;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end

      ST_CHECK: begin
        if (marker_valid(marker_q, MARKER_BASE)) begin
          choise_n = marker_q[2:0];
          num_q_n  = num_frames;
          k_n      = 6'd1;
          pk_clear = 1'b1;
          cnt_n    = 8'd0;
          if ((num_frames == 6'd0) || (num_frames > 6'(MAX_FRAMES))) begin
            // Bad count still clears the marker so the writer is not locked out.
            err     = 1'b1;
            state_n = ST_CLEAR;
          end else begin
            state_n = ST_READ;
          end
        end else begin
          state_n = ST_IDLE;
          gap_n   = GAP_LOAD;
        end
      end

      ST_READ: begin
        addrb = ((32'(pk_count) + 32'd1) << 2) + 32'(FRAME_STRIDE) * (32'(k) - 32'd1);
        enb   = 1'b1;
        if (cnt == 8'(RD_LAT)) begin
          pk_load = 1'b1;
          cnt_n   = 8'd0;
          if (pk_count == CW'(FRAME_WORDS - 1)) begin
            state_n     = ST_PRESENT;
            frame_idx_n = k;
          end
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end

      ST_PRESENT: begin
        frame_valid = 1'b1;
        if (frame_ready) begin
          cnt_n = 8'd0;
          if (k == num_q) begin
            state_n = ST_CLEAR;
          end else begin
            k_n      = k + 6'd1;
            pk_clear = 1'b1;
            state_n  = ST_READ;
          end
        end
      end

      ST_CLEAR: begin
        addrb = MARKER_ADDR;
        enb   = 1'b1;
        web   = 4'hf;
        if (cnt == 8'(WR_HOLD - 1)) begin
          cnt_n   = 8'd0;
          state_n = ST_DONE;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end

      ST_DONE: begin
        done    = 1'b1;
        state_n = ST_IDLE;
        gap_n   = GAP_LOAD;
      end

      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_r_ram.sv
// tb/tb_r_ram.sv - scoreboard bench for r_ram with a 2-cycle-latency BRAM model
module tb_r_ram;

  localparam logic [31:0] MK_ADDR = 32'd8000;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         rd_en = 1'b0;
  logic [5:0]   num_frames = 6'd0;
  logic [31:0]  addrb;
  logic         clkb;
  logic         enb;
  logic         rstb;
  logic [3:0]   web;
  logic [31:0]  dinb;
  logic [31:0]  doutb;
  logic [895:0] frame_data;
  logic [5:0]   frame_idx;
  logic [2:0]   choise;
  logic         frame_valid;
  logic         frame_ready = 1'b1;
  logic         busy;
  logic         done;
  logic         err;

  always #5 clk = ~clk;

  r_ram dut (
    .clk         (clk),
    .reset       (reset),
    .rd_en       (rd_en),
    .num_frames  (num_frames),
    .addrb       (addrb),
    .clkb        (clkb),
    .enb         (enb),
    .rstb        (rstb),
    .web         (web),
    .dinb        (dinb),
    .doutb       (doutb),
    .frame_data  (frame_data),
    .frame_idx   (frame_idx),
    .choise      (choise),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  // BRAM model: read data appears two clocks after the address.
  logic [31:0] mem [0:2047];
  logic [31:0] rd_pipe;
  logic        tb_we = 1'b0;
  logic [31:0] tb_waddr = 32'd0;
  logic [31:0] tb_wdata = 32'd0;

  always @(posedge clk) begin
    rd_pipe <= mem[addrb[12:2]];
    doutb   <= rd_pipe;
    if (tb_we) mem[tb_waddr[12:2]] = tb_wdata;
    else if (enb && web == 4'hf) mem[addrb[12:2]] = dinb;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [895:0] mk_frame(input int k);
    logic [895:0] d;
    d = '0;
    for (int jj = 1; jj <= 28; jj++) d[895-32*(jj-1) -: 32] = {8'(k), 8'(jj), 16'h0};
    return d;
  endfunction

  typedef struct packed {
    logic [5:0]   idx;
    logic [2:0]   ch;
    logic [895:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t sb_e;
  int   n_xfer = 0;

  // Scoreboard monitor: every accepted frame is matched against the next expected one.
  always @(negedge clk) begin
    if (reset && frame_valid && frame_ready) begin
      n_xfer++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected actual_idx=%0d required=none", frame_idx);
      end else begin
        sb_e = exp_q.pop_front();
        chk("sb_frame_idx", 32'(frame_idx), 32'(sb_e.idx));
        chk("sb_choise", 32'(choise), 32'(sb_e.ch));
        checks++;
        if (frame_data !== sb_e.data) begin
          failures++;
          for (int w = 0; w < 28; w++) begin
            if (frame_data[895-32*w -: 32] !== sb_e.data[895-32*w -: 32]) begin
              $display("FAIL sb_frame_data idx=%0d word=%0d actual=%0h required=%0h",
                       sb_e.idx, w + 1, frame_data[895-32*w -: 32], sb_e.data[895-32*w -: 32]);
              break;
            end
          end
        end
      end
    end
  end

  task automatic at_pos();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frames(input int n, input logic [2:0] ch);
    exp_t e;
    for (int k = 1; k <= n; k++) begin
      e.idx  = 6'(k);
      e.ch   = ch;
      e.data = mk_frame(k);
      exp_q.push_back(e);
    end
  endtask

  task automatic prep(input logic [5:0] n, input logic [31:0] marker);
    at_pos();
    rd_en = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    num_frames = n;
    tb_we = 1'b1;
    tb_waddr = MK_ADDR;
    tb_wdata = marker;
    at_pos();
    tb_we = 1'b0;
  endtask

  int           w_done, w_err, w_valid, w_nrd;
  logic [31:0]  w_first_rd, w_max_rd;
  logic         w_first_seen;
  logic [895:0] w_first_data;
  logic [2:0]   w_first_ch;
  logic [5:0]   w_first_idx;

  task automatic run_session(input string tag, input int budget);
    int stop_at;
    w_done = 0; w_err = 0; w_valid = 0; w_nrd = 0;
    w_first_rd = 32'hffffffff; w_max_rd = 32'd0; w_first_seen = 1'b0;
    stop_at = -1;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (done) begin
        w_done++;
        if (stop_at < 0) stop_at = c + 5;
      end
      if (err) w_err++;
      if (frame_valid) begin
        w_valid++;
        if (!w_first_seen) begin
          w_first_seen = 1'b1;
          w_first_data = frame_data;
          w_first_ch   = choise;
          w_first_idx  = frame_idx;
        end
      end
      if (enb && web == 4'h0 && addrb != MK_ADDR) begin
        w_nrd++;
        if (w_first_rd == 32'hffffffff) w_first_rd = addrb;
        if (addrb > w_max_rd) w_max_rd = addrb;
      end
      if (c == stop_at) break;
    end
    chk({tag, "_session_end"}, 32'(stop_at >= 0), 32'd1);
  endtask

  int x0, t1, t2, idle_cnt, nrd, nval, unstable, rd2;
  logic prev_poll, poll_now;
  logic [895:0] snap;

  initial begin
    // Reset state
    #2 reset = 1'b0;
    #1;
    chk("rst_addrb", addrb, 32'd0);
    chk("rst_enb_busy_valid", {29'd0, enb, busy, frame_valid}, 32'd0);
    chk("rst_done_err_rstb", {29'd0, done, err, rstb}, 32'd0);
    chk("rst_web_dinb", {28'd0, web} | dinb, 32'd0);
    chk("rst_idx_choise", {23'd0, frame_idx, choise}, 32'd0);
    chk("rst_frame_data", 32'(|frame_data), 32'd0);
    at_pos();
    reset = 1'b1;

    // Preload all 56 frames: word j of frame k = {k, j, 16'h0}
    at_pos();
    tb_we = 1'b1;
    for (int k = 1; k <= 56; k++) begin
      for (int j = 1; j <= 28; j++) begin
        tb_waddr = 32'(112 * (k - 1) + 4 * j);
        tb_wdata = {8'(k), 8'(j), 16'h0};
        at_pos();
      end
    end
    tb_we = 1'b0;

    // Full session, two frames, mode 3
    prep(6'd2, 32'hf0f0f0f3);
    push_frames(2, 3'd3);
    x0 = n_xfer;
    rd_en = 1'b1;
    run_session("full", 800);
    chk("full_first_rd_addr", w_first_rd, 32'd4);
    chk("full_first_idx", 32'(w_first_idx), 32'd1);
    chk("full_first_word1", w_first_data[895:864], 32'h01010000);
    chk("full_first_word28", w_first_data[31:0], 32'h011c0000);
    chk("full_choise", 32'(w_first_ch), 32'd3);
    chk("full_transfers", 32'(n_xfer - x0), 32'd2);
    chk("full_marker_cleared", mem[MK_ADDR[12:2]], 32'd0);
    chk("full_done_pulses", 32'(w_done), 32'd1);
    chk("full_max_rd", w_max_rd, 32'd224);

    // Invalid marker: mode 7 rejected, repoll every 20 cycles
    prep(6'd2, 32'hf0f0f0f7);
    rd_en = 1'b1;
    t1 = -1; t2 = -1; idle_cnt = 0; nrd = 0; nval = 0; prev_poll = 1'b0;
    for (int c = 0; c < 150 && t2 < 0; c++) begin
      @(negedge clk);
      poll_now = enb && web == 4'h0 && addrb == MK_ADDR;
      if (poll_now && !prev_poll) begin
        if (t1 < 0) t1 = c;
        else t2 = c;
      end else if (t1 >= 0 && !busy) begin
        idle_cnt++;
      end
      if (enb && addrb != MK_ADDR) nrd++;
      if (frame_valid) nval++;
      prev_poll = poll_now;
    end
    chk("inv_poll_interval", 32'(t2 - t1), 32'd20);
    chk("inv_idle_cycles", 32'(idle_cnt), 32'd16);
    chk("inv_no_reads", 32'(nrd + nval), 32'd0);

    // Backpressure: frame 1 held for 50 cycles
    prep(6'd2, 32'hf0f0f0f1);
    push_frames(2, 3'd1);
    frame_ready = 1'b0;
    rd_en = 1'b1;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (frame_valid) break;
    end
    chk("bp_valid_seen", 32'(frame_valid), 32'd1);
    snap = frame_data;
    unstable = 0; rd2 = 0;
    repeat (50) begin
      @(negedge clk);
      if (frame_data !== snap || !frame_valid || frame_idx != 6'd1) unstable++;
      if (enb && web == 4'h0 && addrb != MK_ADDR) rd2++;
    end
    chk("bp_stable", 32'(unstable), 32'd0);
    chk("bp_no_frame2_read", 32'(rd2), 32'd0);
    at_pos();
    frame_ready = 1'b1;
    run_session("bp", 400);
    chk("bp_frame2_first_addr", w_first_rd, 32'd116);
    chk("bp_done_pulses", 32'(w_done), 32'd1);

    // Bad counts: 0 and 57
    for (int b = 0; b < 2; b++) begin
      prep((b == 0) ? 6'd0 : 6'd57, 32'hf0f0f0f2);
      rd_en = 1'b1;
      run_session("bad", 200);
      chk("bad_err_pulses", 32'(w_err), 32'd1);
      chk("bad_no_valid", 32'(w_valid), 32'd0);
      chk("bad_no_reads", 32'(w_nrd), 32'd0);
      chk("bad_marker_cleared", mem[MK_ADDR[12:2]], 32'd0);
      chk("bad_done_pulses", 32'(w_done), 32'd1);
    end

    // Reset at word 10 of frame 1
    prep(6'd1, 32'hf0f0f0f4);
    push_frames(1, 3'd4);
    rd_en = 1'b1;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (enb && addrb == 32'd40) break;
    end
    chk("mid_reached_word10", addrb, 32'd40);
    reset = 1'b0;
    #1;
    chk("mid_rst_addrb", addrb, 32'd0);
    chk("mid_rst_ctrl", {27'd0, enb, busy, frame_valid, done, err}, 32'd0);
    chk("mid_rst_web", 32'(web), 32'd0);
    chk("mid_rst_frame_data", 32'(|frame_data), 32'd0);
    chk("mid_rst_idx_choise", {23'd0, frame_idx, choise}, 32'd0);
    repeat (3) at_pos();
    chk("mid_marker_kept", mem[MK_ADDR[12:2]], 32'hf0f0f0f4);
    reset = 1'b1;
    run_session("mid", 400);
    chk("mid_restart_first_addr", w_first_rd, 32'd4);
    chk("mid_restart_idx", 32'(w_first_idx), 32'd1);
    chk("mid_done_pulses", 32'(w_done), 32'd1);

    // Last legal frame count
    prep(6'd56, 32'hf0f0f0f0);
    push_frames(56, 3'd0);
    x0 = n_xfer;
    rd_en = 1'b1;
    run_session("last", 6000);
    chk("last_max_addr", w_max_rd, 32'd6272);
    chk("last_transfers", 32'(n_xfer - x0), 32'd56);
    chk("last_marker_cleared", mem[MK_ADDR[12:2]], 32'd0);

    rd_en = 1'b0;
    repeat (5) at_pos();
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
